// File: rtl/a0_trace_pkg.sv
// Shared defaults, entry layout and sizing helper for the a0 trace FIFO.
package a0_trace_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 8;
  localparam int TS_WIDTH_DEF   = 16;
  localparam int DROP_WIDTH_DEF = 8;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int LEVEL_WIDTH_DEF = level_width(DEPTH_DEF);

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [TS_WIDTH_DEF-1:0]   ts;
  } trace_entry_t;

endpackage

// File: rtl/a0_trace_fifo_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers, level-based full/empty,
// simultaneous push/pop when full, clear with priority over push and pop.
module sync_fifo
  import a0_trace_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              wdata_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;

  // A pop frees the head slot in the same edge, so a full FIFO may still accept.
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Stale slots are hidden so the head reads zero whenever nothing is queued.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/a0_trace_fifo.sv
// Captures changes of a0 with an optional cycle stamp into a FIFO, flags drops.
// Define A0_TRACE_TIMESTAMP_EN to store a cycle stamp per entry and drive ts_o.
module a0_trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          clear_i,
  input  logic [DATA_WIDTH-1:0]         a0_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [TS_WIDTH-1:0]           ts_o,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          overflow_o,
  output logic [DROP_WIDTH-1:0]         drops_o
);

`ifdef A0_TRACE_TIMESTAMP_EN
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TS_WIDTH-1:0]   ts;
  } entry_t;
  localparam int ENTRY_W = DATA_WIDTH + TS_WIDTH;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drops_q, drops_d;
  logic                  push_req, drop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    wdata, rdata;

  assign last_d   = a0_i;
  assign push_req = (a0_i != last_q) && en_i && !clear_i;
  // Full implies non-empty, so ready_i alone decides whether a slot frees up.
  assign drop     = push_req && fifo_full && !ready_i;

  always_comb begin
    overflow_d = overflow_q;
    drops_d    = drops_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      drops_d    = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drops_q != '1) drops_d = drops_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_q     <= '0;
      overflow_q <= 1'b0;
      drops_q    <= '0;
    end else begin
      last_q     <= last_d;
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
    end
  end

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] cnt_q, cnt_d;
  entry_t              head;

  assign cnt_d = cnt_q + TS_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wdata  = {a0_i, cnt_q};
  assign head   = rdata;
  assign data_o = head.data;
  assign ts_o   = head.ts;
`else
  assign wdata  = a0_i;
  assign data_o = rdata;
  assign ts_o   = '0;
`endif

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push_req),
    .pop_i   (ready_i),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

  assign valid_o    = !fifo_empty;
  assign overflow_o = overflow_q;
  assign drops_o    = drops_q;

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo with a 4-entry FIFO; works with or without timestamps.
module tb_a0_trace_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TW = 16;
  localparam int XW = 8;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_i, en_i, clear_i, ready_i;
  logic [DW-1:0] a0_i;
  logic          valid_o, overflow_o;
  logic [DW-1:0] data_o;
  logic [TW-1:0] ts_o;
  logic [LW-1:0] level_o;
  logic [XW-1:0] drops_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TW), .DROP_WIDTH(XW)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i), .a0_i(a0_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ts_o(ts_o),
    .level_o(level_o), .overflow_o(overflow_o), .drops_o(drops_o)
  );

  // Reset for two edges with a0_i=v; returns just after release so the next edge is stamp 0.
  task automatic do_reset(input logic [DW-1:0] v);
    @(negedge clk);
    rst_i = 1'b0; a0_i = v; en_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; a0_i = 32'd5; en_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0h want=0", valid_o); end
    tests++; if (level_o !== '0) begin fails++; $display("FAIL reset_level got=%0d want=0", level_o); end
    tests++; if (overflow_o !== 1'b0 || drops_o !== '0) begin fails++;
      $display("FAIL reset_ovf got=%0h/%0d want=0/0", overflow_o, drops_o); end
    tests++; if (data_o !== '0 || ts_o !== '0) begin fails++;
      $display("FAIL reset_head got=%0h/%0h want=0/0", data_o, ts_o); end
    rst_i = 1'b1;
    @(negedge clk);
    tests++; if (valid_o !== 1'b1 || data_o !== 32'd5 || ts_o !== 16'd0 || level_o !== 3'd1) begin fails++;
      $display("FAIL first_push got v=%0h d=%0d ts=%0d l=%0d want v=1 d=5 ts=0 l=1", valid_o, data_o, ts_o, level_o); end
    $display("[TB] first entry data=%0d ts=%0d", data_o, ts_o);
  endtask

  task automatic test_order();
    logic [DW-1:0] seq [5] = '{32'd0, 32'd1, 32'd1, 32'd3, 32'd3};
    do_reset(32'd0);
    for (int i = 0; i < 5; i++) begin
      a0_i = seq[i];
      @(negedge clk);
    end
    tests++; if (level_o !== 3'd2) begin fails++; $display("FAIL order_level got=%0d want=2", level_o); end
    tests++; if (data_o !== 32'd1) begin fails++; $display("FAIL order_head1 got=%0d want=1", data_o); end
    ready_i = 1'b1;
    @(negedge clk);
    $display("[TB] pop -> next head data=%0d", data_o);
    tests++; if (valid_o !== 1'b1 || data_o !== 32'd3) begin fails++;
      $display("FAIL order_head2 got v=%0h d=%0d want v=1 d=3", valid_o, data_o); end
    @(negedge clk);
    tests++; if (valid_o !== 1'b0 || level_o !== '0) begin fails++;
      $display("FAIL order_empty got v=%0h l=%0d want v=0 l=0", valid_o, level_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset(32'd0);
    for (int i = 0; i < 6; i++) begin
      a0_i = 32'd11 + i;
      @(negedge clk);
    end
    tests++; if (level_o !== 3'd4) begin fails++; $display("FAIL ovf_level got=%0d want=4", level_o); end
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%0h want=1", overflow_o); end
    tests++; if (drops_o !== 8'd2) begin fails++; $display("FAIL ovf_drops got=%0d want=2", drops_o); end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      $display("[TB] drain data=%0d", data_o);
      tests++; if (valid_o !== 1'b1 || data_o !== 32'd11 + i) begin fails++;
        $display("FAIL ovf_drain%0d got v=%0h d=%0d want v=1 d=%0d", i, valid_o, data_o, 11 + i); end
      @(negedge clk);
    end
    tests++; if (valid_o !== 1'b0 || drops_o !== 8'd2) begin fails++;
      $display("FAIL ovf_after got v=%0h drops=%0d want v=0 drops=2", valid_o, drops_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      a0_i = 32'd21 + i;
      @(negedge clk);
    end
    tests++; if (level_o !== 3'd4) begin fails++; $display("FAIL fpp_fill got=%0d want=4", level_o); end
    a0_i = 32'd25; ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    tests++; if (level_o !== 3'd4 || drops_o !== 8'd2) begin fails++;
      $display("FAIL fpp_level got l=%0d drops=%0d want l=4 drops=2", level_o, drops_o); end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      $display("[TB] drain data=%0d", data_o);
      tests++; if (valid_o !== 1'b1 || data_o !== 32'd22 + i) begin fails++;
        $display("FAIL fpp_drain%0d got v=%0h d=%0d want v=1 d=%0d", i, valid_o, data_o, 22 + i); end
      @(negedge clk);
    end
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL fpp_empty got=%0h want=0", valid_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_timestamp();
    logic [TW-1:0] exp1, exp2;
`ifdef A0_TRACE_TIMESTAMP_EN
    exp1 = 16'd10; exp2 = 16'd13;
`else
    exp1 = 16'd0;  exp2 = 16'd0;
`endif
    do_reset(32'd0);
    repeat (10) @(negedge clk);
    a0_i = 32'd7;
    repeat (3) @(negedge clk);
    a0_i = 32'd9;
    @(negedge clk);
    $display("[TB] ts entry data=%0d ts=%0d", data_o, ts_o);
    tests++; if (data_o !== 32'd7 || ts_o !== exp1) begin fails++;
      $display("FAIL ts_first got d=%0d ts=%0d want d=7 ts=%0d", data_o, ts_o, exp1); end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    $display("[TB] ts entry data=%0d ts=%0d", data_o, ts_o);
    tests++; if (data_o !== 32'd9 || ts_o !== exp2) begin fails++;
      $display("FAIL ts_second got d=%0d ts=%0d want d=9 ts=%0d", data_o, ts_o, exp2); end
  endtask

  task automatic test_clear();
    do_reset(32'd0);
    for (int i = 0; i < 5; i++) begin
      a0_i = 32'd31 + i;
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    tests++; if (level_o !== 3'd3 || overflow_o !== 1'b1 || drops_o !== 8'd1) begin fails++;
      $display("FAIL clr_pre got l=%0d o=%0h d=%0d want l=3 o=1 d=1", level_o, overflow_o, drops_o); end
    clear_i = 1'b1; a0_i = 32'd99;
    @(negedge clk);
    clear_i = 1'b0;
    tests++; if (level_o !== '0 || valid_o !== 1'b0 || overflow_o !== 1'b0 || drops_o !== '0) begin fails++;
      $display("FAIL clr_post got l=%0d v=%0h o=%0h d=%0d want all 0", level_o, valid_o, overflow_o, drops_o); end
    @(negedge clk);
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL clr_nopush got v=%0h want=0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_timestamp();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
